// File: rtl/if_fetch_buf_if.sv
// if_fetch_buf_if
//   Bundles the fetch stage's external signals: the EX redirect request, the
//   synchronous-read IMEM port and the valid/ready head-of-buffer port to decode.
//   master : the fetch stage itself (drives imem_*, out_valid, pc_present, inst, fbuf_count)
//   slave  : the surrounding pipeline / IMEM (drives branch_*, imem_rdata, out_ready)
// Parameters
//   XLEN        PC/address width
//   FBUF_DEPTH  fetch-buffer entries; sets the width of fbuf_count
interface if_fetch_buf_if #(
  parameter int XLEN       = 32,
  parameter int FBUF_DEPTH = 4
);
  logic                          branch_sel;
  logic [XLEN-1:0]               branch_inp;
  logic                          imem_req;
  logic [XLEN-1:0]               imem_addr;
  logic [31:0]                   imem_rdata;
  logic                          out_valid;
  logic                          out_ready;
  logic [XLEN-1:0]               pc_present;
  logic [31:0]                   inst;
  logic [$clog2(FBUF_DEPTH):0]   fbuf_count;

  modport master (
    input  branch_sel, branch_inp, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, pc_present, inst, fbuf_count
  );

  modport slave (
    output branch_sel, branch_inp, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, pc_present, inst, fbuf_count
  );
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf
//   Instruction-fetch stage: fetch PC register with +4 increment, redirect mux,
//   one-word-per-cycle synchronous IMEM read port and a FBUF_DEPTH-entry FIFO of
//   {pc, inst} that decouples fetch from decode stalls.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    if_fetch_buf_if.master
//            branch_sel/branch_inp  redirect request and target from EX
//            imem_req/imem_addr     IMEM read strobe and address
//            imem_rdata             IMEM data, valid one cycle after imem_req
//            out_valid/out_ready    head handshake towards decode
//            pc_present/inst        head entry (registered)
//            fbuf_count             occupied entries
module if_fetch_buf #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FBUF_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_buf_if.master  bus
);

  localparam int AW = $clog2(FBUF_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic [XLEN-1:0] pc_mem   [FBUF_DEPTH];
  logic [31:0]     inst_mem [FBUF_DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;

  logic            out_valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   count_after_pop;
  logic [AW-1:0]   next_head_ptr;

  // Handshake and issue decision. Occupancy counts the in-flight word as already
  // buffered so a returning response always has a free slot to land in.
  always_comb begin
    out_valid       = (count != '0) && !bus.branch_sel;
    pop             = out_valid && bus.out_ready;
    push            = inflight && !bus.branch_sel;
    occupancy       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue           = reset && !bus.branch_sel && (occupancy < (CW+1)'(FBUF_DEPTH));
    count_after_pop = count - CW'(pop);
    next_head_ptr   = head_ptr + AW'(pop);
  end

  // Fetch PC, in-flight tracking and FIFO pointers. A redirect discards both the
  // buffered entries and the response that returns this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
    end else if (bus.branch_sel) begin
      fetch_pc <= bus.branch_inp & ~(XLEN'(3));
      inflight <= 1'b0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      inflight <= issue;
      if (push) begin
        tail_ptr <= tail_ptr + AW'(1);
      end
      head_ptr <= next_head_ptr;
      count    <= count_after_pop + CW'(push);
    end
  end

  // Buffer storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[tail_ptr]   <= inflight_pc;
      inst_mem[tail_ptr] <= bus.imem_rdata;
    end
  end

  // Registered head: preload whatever will sit at the head after this edge. If the
  // buffer drains to empty and the incoming word is the only entry, it bypasses
  // storage straight into the head register. An empty buffer holds the last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_pc   <= '0;
      head_inst <= '0;
    end else if (!bus.branch_sel) begin
      if (count_after_pop != '0) begin
        head_pc   <= pc_mem[next_head_ptr];
        head_inst <= inst_mem[next_head_ptr];
      end else if (push) begin
        head_pc   <= inflight_pc;
        head_inst <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.out_valid  = out_valid;
  assign bus.pc_present = head_pc;
  assign bus.inst       = head_inst;
  assign bus.fbuf_count = count;

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf
//   Scoreboard bench for if_fetch_buf. The driver pushes hand-computed expected
//   PCs into a queue; independent monitors pop and compare on every accepted
//   head. A second instance covers a wrapping reset vector.
module tb_if_fetch_buf;

  logic clk;
  logic reset;
  logic reset2;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] exp_q2 [$];

  if_fetch_buf_if #(.XLEN(32), .FBUF_DEPTH(4)) bus  ();
  if_fetch_buf_if #(.XLEN(32), .FBUF_DEPTH(4)) bus2 ();

  if_fetch_buf #(.XLEN(32), .RESET_VECTOR(32'h0), .FBUF_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  if_fetch_buf #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .FBUF_DEPTH(4)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM content is tagged by address so a wrong pc/inst pairing is visible.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return ~a;
  endfunction

  // Synchronous-read IMEM models; garbage when not requested.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req  ? imem_word(bus.imem_addr)  : 32'hDEAD_BEEF;
    bus2.imem_rdata <= bus2.imem_req ? imem_word(bus2.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor for the main instance: every accepted head must match the queue front.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      if (bus.fbuf_count > 3'd4) begin
        miscompares++;
        $display("[TB] FAIL fbuf_overflow: got %0d, expected <= 4", bus.fbuf_count);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_head: got pc %h, expected none", bus.pc_present);
        end else begin
          e = exp_q.pop_front();
          if (bus.pc_present !== e || bus.inst !== imem_word(e)) begin
            miscompares++;
            $display("[TB] FAIL head: got pc %h inst %h, expected pc %h inst %h",
                     bus.pc_present, bus.inst, e, imem_word(e));
          end
        end
      end
    end
  end

  // Monitor for the wrapping-reset-vector instance.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset2 && bus2.out_valid && bus2.out_ready) begin
      vectors++;
      if (exp_q2.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_head2: got pc %h, expected none", bus2.pc_present);
      end else begin
        e = exp_q2.pop_front();
        if (bus2.pc_present !== e || bus2.inst !== imem_word(e)) begin
          miscompares++;
          $display("[TB] FAIL head2: got pc %h inst %h, expected pc %h inst %h",
                   bus2.pc_present, bus2.inst, e, imem_word(e));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    next_cycle();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.branch_sel = 1'b1;
    bus.branch_inp = target;
    exp_q.delete();
    next_cycle();
    bus.branch_sel = 1'b0;
  endtask

  task automatic wait_count(input logic [2:0] n, input string name);
    for (int i = 0; i < 20; i++) begin
      if (bus.fbuf_count == n) break;
      next_cycle();
    end
    check_output(name, 32'(bus.fbuf_count), 32'(n));
  endtask

  task automatic apply_stimulus();
    // Reset state
    reset = 1'b0;
    bus.branch_sel = 1'b0;
    bus.branch_inp = '0;
    bus.out_ready  = 1'b0;
    repeat (3) next_cycle();
    check_output("rst_imem_req",   32'(bus.imem_req),   32'd0);
    check_output("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_output("rst_fbuf_count", 32'(bus.fbuf_count), 32'd0);
    check_output("rst_pc_present", bus.pc_present,      32'd0);
    check_output("rst_inst",       bus.inst,            32'd0);

    // 1: free-running stream from reset, first valid two edges after release
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    bus.out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_output("t1_imem_req",  32'(bus.imem_req), 32'd1);
    check_output("t1_imem_addr", bus.imem_addr,     32'h0);
    next_cycle();
    check_output("t1_valid_early", 32'(bus.out_valid), 32'd0);
    next_cycle();
    check_output("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check_output("t1_first_pc",    bus.pc_present,     32'h0);
    drain("t1");

    // 2: decode stalled, buffer saturates, then releases in order
    pulse_reset();
    repeat (10) next_cycle();
    check_output("t2_count_sat", 32'(bus.fbuf_count), 32'd4);
    check_output("t2_req_drop",  32'(bus.imem_req),   32'd0);
    check_output("t2_head_pc",   bus.pc_present,      32'h0);
    check_output("t2_head_inst", bus.inst,            32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    drain("t2");

    // 3: redirect with three entries buffered and one in flight
    pulse_reset();
    wait_count(3'd3, "t3_count3");
    bus.branch_sel = 1'b1;
    bus.branch_inp = 32'h100;
    #1;
    check_output("t3_valid_redirect", 32'(bus.out_valid), 32'd0);
    check_output("t3_req_redirect",   32'(bus.imem_req),  32'd0);
    exp_q.delete();
    next_cycle();
    bus.branch_sel = 1'b0;
    #1;
    check_output("t3_count_flush", 32'(bus.fbuf_count), 32'd0);
    check_output("t3_target_req",  32'(bus.imem_req),   32'd1);
    check_output("t3_target_addr", bus.imem_addr,       32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    next_cycle();
    check_output("t3_valid_gap", 32'(bus.out_valid), 32'd0);
    next_cycle();
    check_output("t3_target_valid", 32'(bus.out_valid), 32'd1);
    check_output("t3_target_pc",    bus.pc_present,     32'h100);
    drain("t3");

    // 4: misaligned target is word-aligned; back-to-back redirects, last wins
    redirect(32'h103);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    drain("t4a");
    bus.branch_sel = 1'b1;
    bus.branch_inp = 32'h40;
    next_cycle();
    bus.branch_inp = 32'h80;
    exp_q.delete();
    next_cycle();
    bus.branch_sel = 1'b0;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    exp_q.push_back(32'h88);
    drain("t4b");

    // 6: reset while full with out_ready toggling
    wait_count(3'd4, "t6_full");
    reset = 1'b0;
    bus.out_ready = 1'b1;
    next_cycle();
    check_output("t6_valid",   32'(bus.out_valid),  32'd0);
    check_output("t6_count",   32'(bus.fbuf_count), 32'd0);
    check_output("t6_req",     32'(bus.imem_req),   32'd0);
    check_output("t6_pc_zero", bus.pc_present,      32'd0);
    bus.out_ready = 1'b0;
    next_cycle();
    exp_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    drain("t6");

    // 5: PC wraps silently past 2^32
    exp_q2.push_back(32'hFFFF_FFF8);
    exp_q2.push_back(32'hFFFF_FFFC);
    exp_q2.push_back(32'h0000_0000);
    exp_q2.push_back(32'h0000_0004);
    bus2.out_ready = 1'b1;
    reset2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (exp_q2.size() == 0) break;
      next_cycle();
    end
    bus2.out_ready = 1'b0;
    check_output("t5_drain_left", 32'(exp_q2.size()), 32'd0);
  endtask

  initial begin
    reset2          = 1'b0;
    bus2.branch_sel = 1'b0;
    bus2.branch_inp = '0;
    bus2.out_ready  = 1'b0;
    apply_stimulus();
    repeat (3) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
